// File: rtl/pipeline_pkg.sv
// Shared definitions for the decoded-control pipeline: stage numbering,
// default widths and the layout of one in-flight entry.
package pipeline_pkg;

  // Stage numbering for the default three-stage pipe.
  localparam int STG_EXEC = 0;
  localparam int STG_MEM  = 1;
  localparam int STG_WB   = 2;

  // Default widths.
  localparam int DEF_NUM_STAGES = 3;
  localparam int DEF_CTRL_W     = 41;
  localparam int DEF_RES_W      = 16;
  localparam int DEF_REG_IDX_W  = 3;

  // One in-flight instruction at the default widths. The top declares the
  // same layout with its own parameter widths so it can be resized.
  typedef struct packed {
    logic                      valid;
    logic                      wr;
    logic                      rdy;
    logic [DEF_REG_IDX_W-1:0]  dst;
    logic [DEF_RES_W-1:0]      res;
    logic [DEF_CTRL_W-1:0]     ctrl;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_fwd_select.sv
// Per-source forwarding matcher: finds the youngest in-flight writer of the
// requested register and reports its result or that it is still pending.
module pipe_fwd_select
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int RES_W      = DEF_RES_W,
  parameter int REG_IDX_W  = DEF_REG_IDX_W
) (
  input  logic [NUM_STAGES-1:0]                valid,
  input  logic [NUM_STAGES-1:0]                wr,
  input  logic [NUM_STAGES-1:0]                rdy,
  input  logic [NUM_STAGES-1:0]                flush,
  input  logic [NUM_STAGES-1:0][REG_IDX_W-1:0] dst,
  input  logic [NUM_STAGES-1:0][RES_W-1:0]     res,
  input  logic [REG_IDX_W-1:0]                 src,
  output logic                                 hit,
  output logic [RES_W-1:0]                     data,
  output logic                                 pending
);

  logic found;

  // Priority scan from the youngest stage; the first match shadows older ones.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value held (which would infer a latch).
    found   = 1'b0;
    hit     = 1'b0;
    data    = '0;
    pending = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!found && valid[k] && wr[k] && !flush[k] && (dst[k] == src)) begin
        found   = 1'b1;
        hit     = rdy[k];
        pending = !rdy[k];
        data    = rdy[k] ? res[k] : '0;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl_shift.sv
// Decoded-control shift pipeline: carries one control word per instruction
// from execute to writeback, with per-stage flush, stall bubbles, result
// capture, writeback and operand forwarding / hazard detection.
// Optional PIPE_PERF_CNT_EN adds saturating bubble and flush counters.
// NUM_STAGES must be at least 2.
module pipeline_ctrl_shift
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int RES_W      = DEF_RES_W,
  parameter int REG_IDX_W  = DEF_REG_IDX_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall_i,
  input  logic                                 in_valid_i,
  input  logic [CTRL_W-1:0]                    in_ctrl_i,
  input  logic                                 in_wr_i,
  input  logic [REG_IDX_W-1:0]                 in_dst_i,
  input  logic [NUM_STAGES-1:0]                flush_i,
  input  logic [NUM_STAGES-1:0]                res_we_i,
  input  logic [NUM_STAGES-1:0][RES_W-1:0]     res_i,
  input  logic [REG_IDX_W-1:0]                 src_a_i,
  input  logic [REG_IDX_W-1:0]                 src_b_i,
  output logic [NUM_STAGES-1:0]                stg_valid_o,
  output logic [NUM_STAGES-1:0][CTRL_W-1:0]    stg_ctrl_o,
  output logic [NUM_STAGES-1:0][REG_IDX_W-1:0] stg_dst_o,
  output logic [NUM_STAGES-1:0][RES_W-1:0]     stg_res_o,
  output logic                                 fwd_hit_a_o,
  output logic                                 fwd_hit_b_o,
  output logic [RES_W-1:0]                     fwd_data_a_o,
  output logic [RES_W-1:0]                     fwd_data_b_o,
  output logic                                 hazard_o,
  output logic                                 wb_valid_o,
  output logic [REG_IDX_W-1:0]                 wb_dst_o,
  output logic [RES_W-1:0]                     wb_data_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                          bubble_cnt_o,
  output logic [31:0]                          flush_cnt_o
`endif
);

  localparam int LAST = NUM_STAGES - 1;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  rdy;
    logic [REG_IDX_W-1:0]  dst;
    logic [RES_W-1:0]      res;
    logic [CTRL_W-1:0]     ctrl;
  } entry_t;

  entry_t [NUM_STAGES-1:0] pipe_q;
  entry_t [NUM_STAGES-1:0] pipe_d;

  logic [NUM_STAGES-1:0] stg_wr;
  logic [NUM_STAGES-1:0] stg_rdy;
  logic                  load_bubble;
  logic                  pend_a;
  logic                  pend_b;

  assign load_bubble = !(in_valid_i && !stall_i);

  // Next pipe contents: load or bubble into execute, shift the rest down,
  // killing flushed entries and folding in results captured this cycle.
  always_comb begin
    pipe_d = '0;
    if (!load_bubble) begin
      pipe_d[STG_EXEC].valid = 1'b1;
      pipe_d[STG_EXEC].wr    = in_wr_i;
      pipe_d[STG_EXEC].dst   = in_dst_i;
      pipe_d[STG_EXEC].ctrl  = in_ctrl_i;
    end
    for (int k = 0; k < LAST; k++) begin
      if (!flush_i[k]) begin
        pipe_d[k+1] = pipe_q[k];
        if (res_we_i[k] && pipe_q[k].valid) begin
          pipe_d[k+1].res = res_i[k];
          pipe_d[k+1].rdy = 1'b1;
        end
      end
    end
  end

  // Pipe register: advances every cycle, cleared as a whole on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour and the shift is race-free.
    // The entries are few and their valid bits must start clean, so the
    // whole pipe is reset rather than only the valid bits.
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  // Per-stage views of the pipe for the outputs and the forwarding matchers.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      stg_valid_o[k] = pipe_q[k].valid;
      stg_ctrl_o[k]  = pipe_q[k].valid ? pipe_q[k].ctrl : '0;
      stg_dst_o[k]   = pipe_q[k].dst;
      stg_res_o[k]   = pipe_q[k].res;
      stg_wr[k]      = pipe_q[k].wr;
      stg_rdy[k]     = pipe_q[k].rdy;
    end
  end

  // Writeback from the last stage; a same-cycle result bypasses the stored one.
  always_comb begin
    wb_valid_o = pipe_q[LAST].valid && pipe_q[LAST].wr && !flush_i[LAST];
    wb_dst_o   = pipe_q[LAST].dst;
    wb_data_o  = (res_we_i[LAST] && pipe_q[LAST].valid) ? res_i[LAST]
                                                        : pipe_q[LAST].res;
  end

  pipe_fwd_select #(
    .NUM_STAGES (NUM_STAGES),
    .RES_W      (RES_W),
    .REG_IDX_W  (REG_IDX_W)
  ) u_fwd_a (
    .valid   (stg_valid_o),
    .wr      (stg_wr),
    .rdy     (stg_rdy),
    .flush   (flush_i),
    .dst     (stg_dst_o),
    .res     (stg_res_o),
    .src     (src_a_i),
    .hit     (fwd_hit_a_o),
    .data    (fwd_data_a_o),
    .pending (pend_a)
  );

  pipe_fwd_select #(
    .NUM_STAGES (NUM_STAGES),
    .RES_W      (RES_W),
    .REG_IDX_W  (REG_IDX_W)
  ) u_fwd_b (
    .valid   (stg_valid_o),
    .wr      (stg_wr),
    .rdy     (stg_rdy),
    .flush   (flush_i),
    .dst     (stg_dst_o),
    .res     (stg_res_o),
    .src     (src_b_i),
    .hit     (fwd_hit_b_o),
    .data    (fwd_data_b_o),
    .pending (pend_b)
  );

  assign hazard_o = pend_a || pend_b;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] flush_inc;
  logic [32:0] flush_sum;

  // Number of live entries killed this cycle and the widened running total.
  always_comb begin
    flush_inc = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      flush_inc = flush_inc + 32'(flush_i[k] && pipe_q[k].valid);
    end
    flush_sum = {1'b0, flush_cnt_o} + {1'b0, flush_inc};
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (load_bubble && (bubble_cnt_o != '1)) bubble_cnt_o <= bubble_cnt_o + 32'd1;
      flush_cnt_o <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipeline_ctrl_shift.sv
// Directed bench for pipeline_ctrl_shift at default parameters.
module tb_pipeline_ctrl_shift;

  localparam int N   = 3;
  localparam int CW  = 41;
  localparam int RW  = 16;
  localparam int IW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall_i;
  logic                 in_valid_i;
  logic [CW-1:0]        in_ctrl_i;
  logic                 in_wr_i;
  logic [IW-1:0]        in_dst_i;
  logic [N-1:0]         flush_i;
  logic [N-1:0]         res_we_i;
  logic [N-1:0][RW-1:0] res_i;
  logic [IW-1:0]        src_a_i;
  logic [IW-1:0]        src_b_i;
  logic [N-1:0]         stg_valid_o;
  logic [N-1:0][CW-1:0] stg_ctrl_o;
  logic [N-1:0][IW-1:0] stg_dst_o;
  logic [N-1:0][RW-1:0] stg_res_o;
  logic                 fwd_hit_a_o;
  logic                 fwd_hit_b_o;
  logic [RW-1:0]        fwd_data_a_o;
  logic [RW-1:0]        fwd_data_b_o;
  logic                 hazard_o;
  logic                 wb_valid_o;
  logic [IW-1:0]        wb_dst_o;
  logic [RW-1:0]        wb_data_o;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl_shift dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .in_valid_i   (in_valid_i),
    .in_ctrl_i    (in_ctrl_i),
    .in_wr_i      (in_wr_i),
    .in_dst_i     (in_dst_i),
    .flush_i      (flush_i),
    .res_we_i     (res_we_i),
    .res_i        (res_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .stg_valid_o  (stg_valid_o),
    .stg_ctrl_o   (stg_ctrl_o),
    .stg_dst_o    (stg_dst_o),
    .stg_res_o    (stg_res_o),
    .fwd_hit_a_o  (fwd_hit_a_o),
    .fwd_hit_b_o  (fwd_hit_b_o),
    .fwd_data_a_o (fwd_data_a_o),
    .fwd_data_b_o (fwd_data_b_o),
    .hazard_o     (hazard_o),
    .wb_valid_o   (wb_valid_o),
    .wb_dst_o     (wb_dst_o),
    .wb_data_o    (wb_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [CW-1:0] ctrl, input logic [IW-1:0] dst);
    in_valid_i = 1'b1;
    in_wr_i    = 1'b1;
    in_ctrl_i  = ctrl;
    in_dst_i   = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = '0; res_we_i = '0; res_i = '0;
    src_a_i = '0; src_b_i = '0;
    issue(41'h5, 3'd3);
    src_a_i = 3'd3;

    // Reset held for two cycles with a valid word on the input.
    tick(); tick();
    rst = 1'b0; in_valid_i = 1'b0;
    #1;
    check("rst_valid",  64'(stg_valid_o), 64'h0);
    check("rst_wb",     64'(wb_valid_o),  64'h0);
    check("rst_hazard", 64'(hazard_o),    64'h0);
    check("rst_ctrl0",  64'(stg_ctrl_o[0]), 64'h0);
    src_a_i = '0;

    // Straight flow: issue, capture 0x00AA in execute, commit 3 cycles later.
    issue(41'h1, 3'd3);
    tick();
    in_valid_i = 1'b0; res_we_i = 3'b001; res_i[0] = 16'h00AA;
    #1;
    check("flow_v0",  64'(stg_valid_o), 64'b001);
    check("flow_wb0", 64'(wb_valid_o),  64'h0);
    tick();
    res_we_i = '0;
    #1;
    check("flow_v1",   64'(stg_valid_o),  64'b010);
    check("flow_res1", 64'(stg_res_o[1]), 64'h00AA);
    check("flow_wb1",  64'(wb_valid_o),   64'h0);
    tick();
    check("flow_wbv", 64'(wb_valid_o), 64'h1);
    check("flow_wbd", 64'(wb_dst_o),   64'h3);
    check("flow_wbx", 64'(wb_data_o),  64'h00AA);
    check("flow_c2",  64'(stg_ctrl_o[2]), 64'h1);
    tick();
    check("flow_end", 64'(stg_valid_o), 64'h0);
    check("flow_wbe", 64'(wb_valid_o),  64'h0);

    // Stall bubble between two issues.
    issue(41'h11, 3'd1);
    tick();
    stall_i = 1'b1; in_ctrl_i = 41'h22; in_dst_i = 3'd7;
    tick();
    check("stall_v1", 64'(stg_valid_o), 64'b010);
    stall_i = 1'b0; in_ctrl_i = 41'h33; in_dst_i = 3'd2;
    tick();
    in_valid_i = 1'b0;
    #1;
    check("stall_v2", 64'(stg_valid_o),   64'b101);
    check("stall_c2", 64'(stg_ctrl_o[2]), 64'h11);
    check("stall_c1", 64'(stg_ctrl_o[1]), 64'h0);
    check("stall_c0", 64'(stg_ctrl_o[0]), 64'h33);
    check("stall_wb", 64'(wb_dst_o),      64'h1);
    tick();
    check("stall_v3", 64'(stg_valid_o), 64'b010);
    tick();
    check("stall_v4", 64'(stg_valid_o), 64'b100);
    check("stall_wd", 64'(wb_dst_o),    64'h2);
    tick();

    // Flush of the middle stage; neighbours still commit.
    issue(41'h41, 3'd4); tick();
    issue(41'h42, 3'd5); tick();
    issue(41'h43, 3'd6); tick();
    in_valid_i = 1'b0; src_a_i = 3'd5;
    #1;
    check("fl_v",     64'(stg_valid_o), 64'b111);
    check("fl_haz1",  64'(hazard_o),    64'h1);
    flush_i = 3'b010;
    #1;
    check("fl_haz0",  64'(hazard_o),    64'h0);
    check("fl_wbP",   64'(wb_valid_o),  64'h1);
    check("fl_wbPd",  64'(wb_dst_o),    64'h4);
    tick();
    flush_i = '0;
    #1;
    check("fl_noQ",   64'(wb_valid_o),  64'h0);
    check("fl_v2",    64'(stg_valid_o), 64'b010);
    tick();
    check("fl_wbR",   64'(wb_valid_o),  64'h1);
    check("fl_wbRd",  64'(wb_dst_o),    64'h6);
    flush_i = 3'b100;
    #1;
    check("fl_last",  64'(wb_valid_o),  64'h0);
    flush_i = '0; src_a_i = '0;
    tick();

    // Forward / hazard on R2.
    issue(41'h2, 3'd2);
    tick();
    in_valid_i = 1'b0; src_a_i = 3'd2;
    #1;
    check("fw_haz",  64'(hazard_o),    64'h1);
    check("fw_hit0", 64'(fwd_hit_a_o), 64'h0);
    res_we_i = 3'b001; res_i[0] = 16'h1234;
    tick();
    res_we_i = '0;
    #1;
    check("fw_hit1", 64'(fwd_hit_a_o),  64'h1);
    check("fw_data", 64'(fwd_data_a_o), 64'h1234);
    check("fw_haz0", 64'(hazard_o),     64'h0);
    src_a_i = '0;
    tick(); tick();

    // Priority: two ready R5 writers, the younger wins.
    issue(41'h51, 3'd5);
    tick();
    in_ctrl_i = 41'h52; res_we_i = 3'b001; res_i[0] = 16'h0002;
    tick();
    in_valid_i = 1'b0; res_we_i = 3'b001; res_i[0] = 16'h0001;
    tick();
    res_we_i = '0; src_b_i = 3'd5;
    #1;
    check("pr_hit",  64'(fwd_hit_b_o),  64'h1);
    check("pr_data", 64'(fwd_data_b_o), 64'h0001);
    check("pr_haz",  64'(hazard_o),     64'h0);
    flush_i = 3'b010;
    #1;
    check("pr_fl_hit",  64'(fwd_hit_b_o),  64'h1);
    check("pr_fl_data", 64'(fwd_data_b_o), 64'h0002);
    flush_i = '0; src_a_i = 3'd7;
    #1;
    check("pr_nohit",  64'(fwd_hit_a_o),  64'h0);
    check("pr_nodata", 64'(fwd_data_a_o), 64'h0);
    res_we_i = 3'b100; res_i[2] = 16'hBEEF;
    #1;
    check("wb_byp_v", 64'(wb_valid_o), 64'h1);
    check("wb_byp_d", 64'(wb_data_o),  64'hBEEF);
    check("wb_byp_r", 64'(wb_dst_o),   64'h5);
    res_we_i = '0; src_a_i = '0; src_b_i = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
